block_place_scan: RTL and testbench

//  Parametrised, sequential successor to the combinational piece expander.

---
 rtl/block_place_scan.sv | 146 ++++++++++++++
 tb/tb_block_place_scan.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/block_place_scan.sv
// block_place_scan: sequential piece expander. It walks the PIECE_N x PIECE_N
// piece mask one cell per clock and paints each set cell onto a board-sized
// map at the signed (pos_x, pos_y) offset. Alongside the map it produces the
// merged board, a collision flag and an out-of-bounds flag, and it returns the
// result through a valid/ready handshake.
module block_place_scan #(
  parameter int BOARD_W = 20,
  parameter int BOARD_H = 20,
  parameter int PIECE_N = 4,
  parameter int POS_W   = 9
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [PIECE_N*PIECE_N-1:0] piece_in,
  input  logic [POS_W-1:0]           pos_x,
  input  logic [POS_W-1:0]           pos_y,
  input  logic [BOARD_W*BOARD_H-1:0] board_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [BOARD_W*BOARD_H-1:0] block_out,
  output logic [BOARD_W*BOARD_H-1:0] merged_out,
  output logic                       collide,
  output logic                       oob
);

  localparam int CELLS = PIECE_N * PIECE_N;
  localparam int NB    = BOARD_W * BOARD_H;
  localparam int CNT_W = (CELLS > 1) ? $clog2(CELLS) : 1;
  localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
  // One extra bit so position + offset can never wrap.
  localparam int PW    = POS_W + 1;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t                   state_q, state_nxt;
  logic [CNT_W-1:0]         cnt_q;
  logic [CELLS-1:0]         piece_q;
  logic signed [POS_W-1:0]  px_q, py_q;
  logic [NB-1:0]            board_q;
  logic [NB-1:0]            block_q, merged_q;
  logic                     collide_q, oob_q;

  logic                     last_cell;
  logic                     cell_on;
  logic [CNT_W-1:0]         r_off, c_off;
  logic signed [PW-1:0]     row_s, col_s;
  logic                     in_bounds;
  logic [IDX_W-1:0]         idx;
  logic [NB-1:0]            block_nxt;
  logic                     collide_nxt, oob_nxt;

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign block_out  = block_q;
  assign merged_out = merged_q;
  assign collide    = collide_q;
  assign oob        = oob_q;

  // Geometry of the cell under the counter: board row/col and bounds test.
  always_comb begin
    last_cell = (cnt_q == CNT_W'(CELLS - 1));
    cell_on   = piece_q[cnt_q];
    r_off     = cnt_q / CNT_W'(PIECE_N);
    c_off     = cnt_q % CNT_W'(PIECE_N);
    row_s     = PW'(py_q) + $signed(PW'(r_off));
    col_s     = PW'(px_q) + $signed(PW'(c_off));
    in_bounds = (row_s >= 0) && (row_s < $signed(PW'(BOARD_H))) &&
                (col_s >= 0) && (col_s < $signed(PW'(BOARD_W)));
    // Only meaningful when in_bounds; row and col are then small non-negatives.
    idx       = IDX_W'(unsigned'(row_s)) * IDX_W'(BOARD_W) + IDX_W'(unsigned'(col_s));
  end

  // Next value of the result map and sticky flags for the current cell.
  always_comb begin
    block_nxt   = block_q;
    collide_nxt = collide_q;
    oob_nxt     = oob_q;
    if (cell_on) begin
      if (in_bounds) begin
        block_nxt[idx] = 1'b1;
        if (board_q[idx]) collide_nxt = 1'b1;
      end else begin
        oob_nxt = 1'b1;
      end
    end
  end

  // Next-state logic for the IDLE -> SCAN -> DONE handshake loop.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_nxt = SCAN;
      SCAN:    if (last_cell) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_nxt;
  end

  // Request capture: operands are held for the whole scan, not reset.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && in_valid) begin
      piece_q <= piece_in;
      px_q    <= pos_x;
      py_q    <= pos_y;
      board_q <= board_in;
    end
  end

  // Cell counter and result registers; cleared on accept, built during SCAN.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      block_q   <= '0;
      merged_q  <= '0;
      collide_q <= 1'b0;
      oob_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          cnt_q     <= '0;
          block_q   <= '0;
          merged_q  <= '0;
          collide_q <= 1'b0;
          oob_q     <= 1'b0;
        end
        SCAN: begin
          block_q   <= block_nxt;
          collide_q <= collide_nxt;
          oob_q     <= oob_nxt;
          if (last_cell) merged_q <= board_q | block_nxt;
          else           cnt_q    <= cnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_block_place_scan.sv
// Bench for block_place_scan: fixed placement vectors, handshake and reset
// corner sequences, then random requests against a placement model.
module tb_block_place_scan;

  localparam int BW = 20;
  localparam int BH = 20;
  localparam int PN = 4;
  localparam int PW = 9;
  localparam int NB = BW * BH;
  localparam int NC = PN * PN;
  // Edges after the accepting edge until out_valid is seen (17 counting it).
  localparam int LAT = NC;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, out_valid, out_ready, collide, oob;
  logic [NC-1:0] piece_in;
  logic [PW-1:0] pos_x, pos_y;
  logic [NB-1:0] board_in, block_out, merged_out;

  int checks   = 0;
  int failures = 0;

  block_place_scan #(.BOARD_W(BW), .BOARD_H(BH), .PIECE_N(PN), .POS_W(PW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .piece_in(piece_in), .pos_x(pos_x), .pos_y(pos_y), .board_in(board_in),
    .out_valid(out_valid), .out_ready(out_ready), .block_out(block_out),
    .merged_out(merged_out), .collide(collide), .oob(oob)
  );

  always #5 clk = ~clk;

  typedef struct {
    string         name;
    logic [NC-1:0] piece;
    logic [PW-1:0] x, y;
    logic [NB-1:0] board;
    logic [NB-1:0] exp_blk;
    logic          exp_col, exp_oob;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [NB-1:0] act, input logic [NB-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Placement by direct arithmetic over the piece cells.
  function automatic void model(input logic [NC-1:0] p, input logic [PW-1:0] x, input logic [PW-1:0] y,
                                input logic [NB-1:0] b, output logic [NB-1:0] blk,
                                output logic col, output logic ob);
    int sx, sy, row, cc;
    sx = int'($signed(x));
    sy = int'($signed(y));
    blk = '0; col = 1'b0; ob = 1'b0;
    for (int k = 0; k < NC; k++) begin
      if (p[k]) begin
        row = sy + k / PN;
        cc  = sx + k % PN;
        if (row >= 0 && row < BH && cc >= 0 && cc < BW) begin
          blk[row*BW+cc] = 1'b1;
          if (b[row*BW+cc]) col = 1'b1;
        end else begin
          ob = 1'b1;
        end
      end
    end
  endfunction

  function automatic logic [NB-1:0] rand_board();
    logic [NB-1:0] b;
    for (int i = 0; i < NB; i++) b[i] = ($urandom_range(0, 3) == 0);
    return b;
  endfunction

  // Present one request; returns at the negedge after the accepting edge,
  // with the input bus scrambled so late sampling would be visible.
  task automatic start_req(input logic [NC-1:0] p, input logic [PW-1:0] x, input logic [PW-1:0] y,
                           input logic [NB-1:0] b);
    @(negedge clk);
    chk("in_ready_before_req", {399'd0, in_ready}, 1);
    piece_in = p; pos_x = x; pos_y = y; board_in = b;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    piece_in = NC'($urandom);
    pos_x    = PW'($urandom);
    pos_y    = PW'($urandom);
    board_in = rand_board();
  endtask

  task automatic wait_done(input string name);
    int lat;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk({name, "_latency"}, NB'(lat), NB'(LAT));
  endtask

  task automatic check_result(input string name, input logic [NB-1:0] b, input logic [NB-1:0] eblk,
                              input logic ecol, input logic eoob);
    chk({name, "_block"},   block_out,          eblk);
    chk({name, "_merged"},  merged_out,         b | eblk);
    chk({name, "_collide"}, {399'd0, collide},  {399'd0, ecol});
    chk({name, "_oob"},     {399'd0, oob},      {399'd0, eoob});
  endtask

  task automatic finish_req(input string name);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({name, "_idle_out_valid"}, {399'd0, out_valid}, 0);
    chk({name, "_idle_in_ready"},  {399'd0, in_ready},  1);
  endtask

  task automatic run_vec(input vec_t v);
    start_req(v.piece, v.x, v.y, v.board);
    wait_done(v.name);
    check_result(v.name, v.board, v.exp_blk, v.exp_col, v.exp_oob);
    finish_req(v.name);
  endtask

  initial begin
    logic [NB-1:0] snap_blk, snap_mrg, rb, eblk;
    logic          snap_col, snap_oob, ecol, eoob;
    logic [NC-1:0] rp;
    logic [PW-1:0] rx, ry;

    // T-piece 0x0072 = cells 1,4,5,6 -> (3,6),(4,5),(4,6),(4,7) at x=5,y=3.
    vecs[0].name = "t_piece"; vecs[0].piece = 16'h0072; vecs[0].x = 9'd5; vecs[0].y = 9'd3;
    vecs[0].board = '0; vecs[0].exp_blk = '0;
    vecs[0].exp_blk[66] = 1'b1; vecs[0].exp_blk[85] = 1'b1;
    vecs[0].exp_blk[86] = 1'b1; vecs[0].exp_blk[87] = 1'b1;
    vecs[0].exp_col = 1'b0; vecs[0].exp_oob = 1'b0;
    // O-piece at the right edge: column 20 is dropped, never wrapped.
    vecs[1].name = "o_edge"; vecs[1].piece = 16'h0033; vecs[1].x = 9'd19; vecs[1].y = 9'd0;
    vecs[1].board = '0; vecs[1].exp_blk = '0;
    vecs[1].exp_blk[19] = 1'b1; vecs[1].exp_blk[39] = 1'b1;
    vecs[1].exp_col = 1'b0; vecs[1].exp_oob = 1'b1;
    // I-piece on row 2 over an occupied cell 42.
    vecs[2].name = "i_collide"; vecs[2].piece = 16'h000F; vecs[2].x = 9'd0; vecs[2].y = 9'd2;
    vecs[2].board = '0; vecs[2].board[42] = 1'b1; vecs[2].exp_blk = '0;
    vecs[2].exp_blk[40] = 1'b1; vecs[2].exp_blk[41] = 1'b1;
    vecs[2].exp_blk[42] = 1'b1; vecs[2].exp_blk[43] = 1'b1;
    vecs[2].exp_col = 1'b1; vecs[2].exp_oob = 1'b0;
    // Negative x: the empty cell 0 would be off-board, the set cell 1 lands on 0.
    vecs[3].name = "neg_x"; vecs[3].piece = 16'h0002; vecs[3].x = 9'h1FF; vecs[3].y = 9'd0;
    vecs[3].board = '0; vecs[3].exp_blk = '0; vecs[3].exp_blk[0] = 1'b1;
    vecs[3].exp_col = 1'b0; vecs[3].exp_oob = 1'b0;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    piece_in = '0; pos_x = '0; pos_y = '0; board_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_in_ready",  {399'd0, in_ready},  1);
    chk("reset_out_valid", {399'd0, out_valid}, 0);
    chk("reset_block",     block_out,  '0);
    chk("reset_merged",    merged_out, '0);
    chk("reset_collide",   {399'd0, collide}, 0);
    chk("reset_oob",       {399'd0, oob},     0);

    for (int i = 0; i < 4; i++) run_vec(vecs[i]);

    // Consumer stalls in DONE while a second request is offered.
    start_req(vecs[2].piece, vecs[2].x, vecs[2].y, vecs[2].board);
    wait_done("stall");
    snap_blk = block_out; snap_mrg = merged_out; snap_col = collide; snap_oob = oob;
    for (int i = 0; i < 5; i++) begin
      in_valid = (i == 2);
      piece_in = 16'h0072; pos_x = 9'd5; pos_y = 9'd3; board_in = '0;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      chk("stall_out_valid", {399'd0, out_valid}, 1);
      chk("stall_in_ready",  {399'd0, in_ready},  0);
      chk("stall_block",     block_out,  snap_blk);
      chk("stall_merged",    merged_out, snap_mrg);
      chk("stall_flags",     {398'd0, collide, oob}, {398'd0, snap_col, snap_oob});
    end
    finish_req("stall");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("stall_not_taken", {398'd0, in_ready, out_valid}, {398'd0, 1'b1, 1'b0});
      chk("stall_hold_block", block_out, vecs[2].exp_blk);
    end
    run_vec(vecs[0]);

    // Reset in the middle of a scan discards the partial result.
    start_req(vecs[2].piece, vecs[2].x, vecs[2].y, vecs[2].board);
    repeat (8) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("midreset_in_ready",  {399'd0, in_ready},  1);
    chk("midreset_out_valid", {399'd0, out_valid}, 0);
    chk("midreset_block",     block_out,  '0);
    chk("midreset_merged",    merged_out, '0);
    chk("midreset_flags",     {398'd0, collide, oob}, 0);
    run_vec(vecs[1]);

    // Random requests against the model, with random consumer stalls.
    for (int n = 0; n < 40; n++) begin
      rp = NC'($urandom);
      rx = PW'($urandom_range(0, 28) - 5);
      ry = PW'($urandom_range(0, 28) - 5);
      if (n % 8 == 0) begin
        rx = PW'($urandom);
        ry = PW'($urandom);
      end
      rb = rand_board();
      model(rp, rx, ry, rb, eblk, ecol, eoob);
      start_req(rp, rx, ry, rb);
      wait_done("rand");
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        @(negedge clk);
      end
      check_result("rand", rb, eblk, ecol, eoob);
      finish_req("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
